// File: rtl/b_code_pkg.sv
// IRIG-B shared definitions: symbol codes, frame layout, pulse widths and BCD helpers.
// Shared between the B-code encoder and the loopback decoder.
package b_code_pkg;

  localparam int unsigned FRAME_SYMS = 100;
  localparam int unsigned SYM_MS     = 10;
  localparam int unsigned SYM_W      = 7;
  localparam int unsigned MS_W       = 4;
  localparam int unsigned SBS_W      = 17;
  localparam int unsigned CTRL_W     = 18;
  localparam int unsigned BIN_W      = 10;

  localparam logic [7:0] BCODE_IDLE = 8'h00;
  localparam logic [7:0] BCODE_P    = 8'h70;
  localparam logic [7:0] BCODE_0    = 8'h30;
  localparam logic [7:0] BCODE_1    = 8'h31;

  localparam logic [MS_W-1:0] PW_ZERO_MS = 4'd2;
  localparam logic [MS_W-1:0] PW_ONE_MS  = 4'd5;
  localparam logic [MS_W-1:0] PW_P_MS    = 4'd8;

  localparam int unsigned POS_SEC_U   = 1;
  localparam int unsigned POS_SEC_T   = 6;
  localparam int unsigned POS_MIN_U   = 10;
  localparam int unsigned POS_MIN_T   = 15;
  localparam int unsigned POS_HR_U    = 20;
  localparam int unsigned POS_HR_T    = 25;
  localparam int unsigned POS_DAY_U   = 30;
  localparam int unsigned POS_DAY_T   = 35;
  localparam int unsigned POS_DAY_H   = 40;
  localparam int unsigned POS_YR_U    = 50;
  localparam int unsigned POS_YR_T    = 55;
  localparam int unsigned POS_CTRL_LO = 60;
  localparam int unsigned POS_CTRL_HI = 70;
  localparam int unsigned POS_SBS_LO  = 80;
  localparam int unsigned POS_SBS_HI  = 90;

  localparam int unsigned NUM_P = 11;
  localparam int unsigned P_POS [NUM_P] = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};

  typedef struct packed {
    logic [3:0] yr_t;
    logic [3:0] yr_u;
    logic [1:0] day_h;
    logic [3:0] day_t;
    logic [3:0] day_u;
    logic [1:0] hr_t;
    logic [3:0] hr_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } time_snap_t;

  function automatic logic [FRAME_SYMS-1:0] p_marker_mask();
    logic [FRAME_SYMS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_P; i++) m[SYM_W'(P_POS[i])] = 1'b1;
    return m;
  endfunction

  localparam logic [FRAME_SYMS-1:0] P_MASK = p_marker_mask();

  // Three BCD digits to binary using x100 = 64+32+4 and x10 = 8+2.
  function automatic logic [BIN_W-1:0] bcd3_to_bin(input logic [3:0] h, input logic [3:0] t,
                                                   input logic [3:0] u);
    return BIN_W'({h, 6'b0}) + BIN_W'({h, 5'b0}) + BIN_W'({h, 2'b0})
         + BIN_W'({t, 3'b0}) + BIN_W'({t, 1'b0}) + BIN_W'(u);
  endfunction

  function automatic logic snap_range_err(input time_snap_t s);
    logic [BIN_W-1:0] hours;
    logic [BIN_W-1:0] day;
    hours = bcd3_to_bin(4'd0, {2'b0, s.hr_t}, s.hr_u);
    day   = bcd3_to_bin({2'b0, s.day_h}, s.day_t, s.day_u);
    return (s.sec_u > 4'd9) || (s.min_u > 4'd9) || (s.hr_u > 4'd9) ||
           (s.day_u > 4'd9) || (s.day_t > 4'd9) || (s.yr_u > 4'd9) || (s.yr_t > 4'd9) ||
           (s.sec_t > 3'd5) || (s.min_t > 3'd5) ||
           (hours > BIN_W'(23)) || (day > BIN_W'(366)) || (day == '0);
  endfunction

  function automatic logic [MS_W-1:0] pulse_ms(input logic [7:0] code);
    case (code)
      BCODE_P: return PW_P_MS;
      BCODE_1: return PW_ONE_MS;
      BCODE_0: return PW_ZERO_MS;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/b_code_sbs_calc.sv
// Straight-binary seconds-of-day from a BCD h/m/s snapshot, shift-add only.
// Stage 1 converts BCD to binary, stage 2 forms the weighted sum; done_o pulses with it.
module b_code_sbs_calc
  import b_code_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       hr_t_i,
  input  logic [3:0]       hr_u_i,
  input  logic [2:0]       min_t_i,
  input  logic [3:0]       min_u_i,
  input  logic [2:0]       sec_t_i,
  input  logic [3:0]       sec_u_i,
  output logic [SBS_W-1:0] sbs_o,
  output logic             done_o
);

  localparam int unsigned HR_W  = 6;
  localparam int unsigned MIN_W = 7;

  logic [HR_W-1:0]  hr_d, hr_q;
  logic [MIN_W-1:0] min_d, min_q;
  logic [MIN_W-1:0] sec_d, sec_q;
  logic             v1_q;
  logic [SBS_W-1:0] sbs_d, sbs_q;
  logic             done_q;

  always_comb begin
    hr_d  = HR_W'({hr_t_i, 3'b0}) + HR_W'({hr_t_i, 1'b0}) + HR_W'(hr_u_i);
    min_d = MIN_W'({min_t_i, 3'b0}) + MIN_W'({min_t_i, 1'b0}) + MIN_W'(min_u_i);
    sec_d = MIN_W'({sec_t_i, 3'b0}) + MIN_W'({sec_t_i, 1'b0}) + MIN_W'(sec_u_i);
    // x3600 = 2048+1024+512+16, x60 = 32+16+8+4; wraps modulo 2^17 for bad input
    sbs_d = SBS_W'({hr_q, 11'b0}) + SBS_W'({hr_q, 10'b0}) + SBS_W'({hr_q, 9'b0})
          + SBS_W'({hr_q, 4'b0})
          + SBS_W'({min_q, 5'b0}) + SBS_W'({min_q, 4'b0}) + SBS_W'({min_q, 3'b0})
          + SBS_W'({min_q, 2'b0})
          + SBS_W'(sec_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      v1_q   <= 1'b0;
      sbs_q  <= '0;
      done_q <= 1'b0;
    end else begin
      v1_q   <= start_i;
      done_q <= v1_q;
      if (start_i) begin
        hr_q  <= hr_d;
        min_q <= min_d;
        sec_q <= sec_d;
      end
      if (v1_q) sbs_q <= sbs_d;
    end
  end

  assign sbs_o  = sbs_q;
  assign done_o = done_q;

endmodule

// File: rtl/b_code_encode.sv
// IRIG-B frame generator: 100 x 10 ms symbols per second from a latched BCD time snapshot.
// Drives the per-symbol code stream for the decoder and the pulse-width DC level line.
module b_code_encode
  import b_code_pkg::*;
#(
  parameter logic [31:0]       CNT_1MS_MAX = 32'd124_999,
  parameter logic [CTRL_W-1:0] CTRL_BITS   = 18'd0
) (
  input  logic             pll_c0,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       miao_gewei,
  input  logic [2:0]       miao_shiwei,
  input  logic [3:0]       fen_gewei,
  input  logic [2:0]       fen_shiwei,
  input  logic [3:0]       shi_gewei,
  input  logic [1:0]       shi_shiwei,
  input  logic [3:0]       day_gewei,
  input  logic [3:0]       day_shiwei,
  input  logic [1:0]       day_baiwei,
  input  logic [3:0]       year_gewei,
  input  logic [3:0]       year_shiwei,
  output logic [7:0]       b_code_type,
  output logic             b_code_dc,
  output logic [SYM_W-1:0] sym_idx,
  output logic             frame_start,
  output logic             bcd_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_1ms_q, cnt_1ms_d;
  logic [MS_W-1:0]       cnt_ms_q, cnt_ms_d;
  logic [SYM_W-1:0]      sym_q, sym_d;
  logic                  new_frame;
  time_snap_t            snap_in, snap_q;
  logic [SBS_W-1:0]      sbs_calc, sbs_q;
  logic                  sbs_done;
  logic [FRAME_SYMS-1:0] frame_bits;
  logic [7:0]            type_d, type_q;
  logic                  dc_d, dc_q;
  logic                  fs_q, err_q;

  always_comb begin
    snap_in       = '0;
    snap_in.sec_u = miao_gewei;
    snap_in.sec_t = miao_shiwei;
    snap_in.min_u = fen_gewei;
    snap_in.min_t = fen_shiwei;
    snap_in.hr_u  = shi_gewei;
    snap_in.hr_t  = shi_shiwei;
    snap_in.day_u = day_gewei;
    snap_in.day_t = day_shiwei;
    snap_in.day_h = day_baiwei;
    snap_in.yr_u  = year_gewei;
    snap_in.yr_t  = year_shiwei;
  end

  // Timing chain and frame sequencing; a new frame only begins from IDLE or at the end of symbol 99.
  always_comb begin
    state_d   = state_q;
    cnt_1ms_d = cnt_1ms_q;
    cnt_ms_d  = cnt_ms_q;
    sym_d     = sym_q;
    new_frame = 1'b0;
    if (state_q == IDLE) begin
      if (en) begin
        state_d   = RUN;
        new_frame = 1'b1;
      end
    end else if (cnt_1ms_q != CNT_1MS_MAX) begin
      cnt_1ms_d = cnt_1ms_q + 32'd1;
    end else begin
      cnt_1ms_d = '0;
      if (cnt_ms_q != MS_W'(SYM_MS - 1)) begin
        cnt_ms_d = cnt_ms_q + MS_W'(1);
      end else begin
        cnt_ms_d = '0;
        if (sym_q != SYM_W'(FRAME_SYMS - 1)) begin
          sym_d = sym_q + SYM_W'(1);
        end else begin
          sym_d = '0;
          if (en) new_frame = 1'b1;
          else    state_d   = IDLE;
        end
      end
    end
  end

  always_comb begin
    frame_bits                          = '0;
    frame_bits[POS_SEC_U +: 4]          = snap_q.sec_u;
    frame_bits[POS_SEC_T +: 3]          = snap_q.sec_t;
    frame_bits[POS_MIN_U +: 4]          = snap_q.min_u;
    frame_bits[POS_MIN_T +: 3]          = snap_q.min_t;
    frame_bits[POS_HR_U +: 4]           = snap_q.hr_u;
    frame_bits[POS_HR_T +: 2]           = snap_q.hr_t;
    frame_bits[POS_DAY_U +: 4]          = snap_q.day_u;
    frame_bits[POS_DAY_T +: 4]          = snap_q.day_t;
    frame_bits[POS_DAY_H +: 2]          = snap_q.day_h;
    frame_bits[POS_YR_U +: 4]           = snap_q.yr_u;
    frame_bits[POS_YR_T +: 4]           = snap_q.yr_t;
    frame_bits[POS_CTRL_LO +: 9]        = CTRL_BITS[8:0];
    frame_bits[POS_CTRL_HI +: 9]        = CTRL_BITS[17:9];
    frame_bits[POS_SBS_LO +: 9]         = sbs_q[8:0];
    frame_bits[POS_SBS_HI +: 8]         = sbs_q[16:9];
  end

  // Outputs are computed from the next counter values so code, level and index move together.
  always_comb begin
    type_d = BCODE_IDLE;
    dc_d   = 1'b0;
    if (state_d == RUN) begin
      if (P_MASK[sym_d])          type_d = BCODE_P;
      else if (frame_bits[sym_d]) type_d = BCODE_1;
      else                        type_d = BCODE_0;
      dc_d = (cnt_ms_d < pulse_ms(type_d));
    end
  end

  always_ff @(posedge pll_c0 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_1ms_q <= '0;
      cnt_ms_q  <= '0;
      sym_q     <= '0;
      snap_q    <= '0;
      sbs_q     <= '0;
      type_q    <= BCODE_IDLE;
      dc_q      <= 1'b0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_1ms_q <= cnt_1ms_d;
      cnt_ms_q  <= cnt_ms_d;
      sym_q     <= sym_d;
      type_q    <= type_d;
      dc_q      <= dc_d;
      fs_q      <= new_frame;
      err_q     <= new_frame && snap_range_err(snap_in);
      if (new_frame) snap_q <= snap_in;
      if (sbs_done)  sbs_q  <= sbs_calc;
    end
  end

  // SBS is recomputed right after each snapshot, long before symbol 80.
  b_code_sbs_calc u_sbs (
    .clk_i   (pll_c0),
    .rst_i   (rst),
    .start_i (fs_q),
    .hr_t_i  (snap_q.hr_t),
    .hr_u_i  (snap_q.hr_u),
    .min_t_i (snap_q.min_t),
    .min_u_i (snap_q.min_u),
    .sec_t_i (snap_q.sec_t),
    .sec_u_i (snap_q.sec_u),
    .sbs_o   (sbs_calc),
    .done_o  (sbs_done)
  );

  assign b_code_type = type_q;
  assign b_code_dc   = dc_q;
  assign sym_idx     = sym_q;
  assign frame_start = fs_q;
  assign bcd_err     = err_q;

endmodule

// File: tb/tb_b_code_encode.sv
// Self-checking bench for b_code_encode with a shortened millisecond tick.
// Expected frames come from an arithmetic model of the IRIG-B layout.
module tb_b_code_encode;

  localparam logic [31:0] CNT_MAX = 32'd2;
  localparam int          MS_CYC  = 3;
  localparam int          SYM_CYC = 30;
  localparam logic [17:0] CTRL    = 18'h2A5C3;

  localparam int ACT_NONE   = 0;
  localparam int ACT_2359   = 1;
  localparam int ACT_RAND   = 2;
  localparam int ACT_EN0    = 3;
  localparam int ACT_RST    = 4;
  localparam int ACT_BADSEC = 5;
  localparam int ACT_DAY0   = 6;

  logic       clk;
  logic       rst, en;
  logic [3:0] su, mu, hu, du, dt, yu, yt;
  logic [2:0] st, mt;
  logic [1:0] ht, dh;
  logic [7:0] b_code_type;
  logic       b_code_dc;
  logic [6:0] sym_idx;
  logic       frame_start, bcd_err;

  int errors = 0;
  int checks = 0;
  int exp_code [100];
  int exp_err;
  int sbs;

  b_code_encode #(.CNT_1MS_MAX(CNT_MAX), .CTRL_BITS(CTRL)) dut (
    .pll_c0      (clk),
    .rst         (rst),
    .en          (en),
    .miao_gewei  (su),
    .miao_shiwei (st),
    .fen_gewei   (mu),
    .fen_shiwei  (mt),
    .shi_gewei   (hu),
    .shi_shiwei  (ht),
    .day_gewei   (du),
    .day_shiwei  (dt),
    .day_baiwei  (dh),
    .year_gewei  (yu),
    .year_shiwei (yt),
    .b_code_type (b_code_type),
    .b_code_dc   (b_code_dc),
    .sym_idx     (sym_idx),
    .frame_start (frame_start),
    .bcd_err     (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int a_ht, input int a_hu, input int a_mt, input int a_mu,
                          input int a_st, input int a_su, input int a_dh, input int a_dt,
                          input int a_du, input int a_yt, input int a_yu);
    ht = 2'(a_ht); hu = 4'(a_hu); mt = 3'(a_mt); mu = 4'(a_mu);
    st = 3'(a_st); su = 4'(a_su); dh = 2'(a_dh); dt = 4'(a_dt);
    du = 4'(a_du); yt = 4'(a_yt); yu = 4'(a_yu);
  endtask

  task automatic set_rand();
    set_time(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
  endtask

  function automatic void put_field(input int pos, input int val, input int w);
    for (int i = 0; i < w; i++) exp_code[pos + i] = ((val >> i) & 1) != 0 ? 'h31 : 'h30;
  endfunction

  // Reference frame from the values currently driven on the time inputs.
  task automatic build_expect();
    int h, m, s, day, v;
    h   = int'(ht) * 10 + int'(hu);
    m   = int'(mt) * 10 + int'(mu);
    s   = int'(st) * 10 + int'(su);
    day = int'(dh) * 100 + int'(dt) * 10 + int'(du);
    v   = (h * 3600 + m * 60 + s) % 131072;
    for (int i = 0; i < 100; i++) exp_code[i] = 'h30;
    put_field(1, int'(su), 4);  put_field(6, int'(st), 3);
    put_field(10, int'(mu), 4); put_field(15, int'(mt), 3);
    put_field(20, int'(hu), 4); put_field(25, int'(ht), 2);
    put_field(30, int'(du), 4); put_field(35, int'(dt), 4); put_field(40, int'(dh), 2);
    put_field(50, int'(yu), 4); put_field(55, int'(yt), 4);
    put_field(60, int'(CTRL) & 'h1FF, 9); put_field(70, int'(CTRL) >> 9, 9);
    put_field(80, v & 'h1FF, 9); put_field(90, v >> 9, 8);
    for (int i = 0; i < 100; i++) if (i == 0 || i % 10 == 9) exp_code[i] = 'h70;
    exp_err = (su > 9 || mu > 9 || hu > 9 || du > 9 || dt > 9 || yu > 9 || yt > 9 ||
               st > 5 || mt > 5 || h > 23 || day > 366 || day == 0) ? 1 : 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_type"}, int'(b_code_type), 0);
    check({tag, "_dc"}, int'(b_code_dc), 0);
    check({tag, "_idx"}, int'(sym_idx), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_err"}, int'(bcd_err), 0);
  endtask

  task automatic do_act(input int kind);
    case (kind)
      ACT_2359:   set_time(2, 3, 5, 9, 5, 9, 3, 6, 5, 2, 5);
      ACT_RAND:   set_rand();
      ACT_EN0:    en = 1'b0;
      ACT_BADSEC: set_time(0, 7, 4, 1, 3, 10, 0, 4, 5, 3, 0);
      ACT_DAY0:   set_time(1, 1, 1, 1, 1, 7, 0, 0, 0, 2, 6);
      ACT_RST: begin
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int act_sym, input int act_kind, input bit b2b,
                           output int obs_sbs);
    int n, hi, bad, ecode, w;
    n = 0;
    obs_sbs = 0;
    @(negedge clk);
    while (!frame_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_start", int'(frame_start), 1);
    if (!frame_start) return;
    if (b2b) check("b2b_gap", n, 0);
    build_expect();
    check("bcd_err", int'(bcd_err), exp_err);
    for (int s = 0; s < 100; s++) begin
      hi = 0;
      bad = 0;
      ecode = exp_code[s];
      w = (ecode == 'h70 ? 8 : (ecode == 'h31 ? 5 : 2)) * MS_CYC;
      for (int c = 0; c < SYM_CYC; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (c == 0) begin
          check($sformatf("type[%0d]", s), int'(b_code_type), ecode);
          check($sformatf("idx[%0d]", s), int'(sym_idx), s);
          if (b_code_type == 8'h31 && s >= 80 && s <= 88) obs_sbs |= 1 << (s - 80);
          if (b_code_type == 8'h31 && s >= 90 && s <= 97) obs_sbs |= 1 << (s - 81);
        end else if (int'(b_code_type) != ecode || int'(sym_idx) != s) begin
          bad++;
        end
        if ((s > 0 || c > 0) && (frame_start || bcd_err)) bad++;
        if (b_code_dc) hi++;
        if (b_code_dc != (c < w)) bad++;
        if (s == act_sym && c == 0) begin
          do_act(act_kind);
          if (act_kind == ACT_RST) return;
        end
      end
      check($sformatf("dc_hi[%0d]", s), hi, w);
      check($sformatf("hold[%0d]", s), bad, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    set_time(1, 2, 3, 4, 5, 6, 1, 2, 3, 2, 4);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_quiet("idle_en0");

    en = 1'b1;
    run_frame(40, ACT_2359, 1'b0, sbs);
    check("sbs_123456", sbs, 45296);
    run_frame(60, ACT_RAND, 1'b1, sbs);
    check("sbs_235959", sbs, 86399);
    repeat (3) run_frame(int'($urandom_range(1, 98)), ACT_RAND, 1'b1, sbs);
    run_frame(70, ACT_BADSEC, 1'b1, sbs);
    run_frame(50, ACT_DAY0, 1'b1, sbs);
    run_frame(50, ACT_EN0, 1'b1, sbs);
    repeat (3) @(negedge clk);
    check_quiet("idle_after");

    set_time(1, 9, 0, 7, 2, 2, 2, 0, 1, 1, 9);
    en = 1'b1;
    run_frame(30, ACT_RST, 1'b0, sbs);
    repeat (2) @(negedge clk);
    check_quiet("rst_hold");
    set_time(0, 8, 1, 5, 4, 2, 2, 0, 0, 9, 9);
    rst = 1'b0;
    run_frame(20, ACT_EN0, 1'b0, sbs);
    check("sbs_post_rst", sbs, 29742);
    repeat (3) @(negedge clk);
    check_quiet("idle_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
